c7bexu_lsu_ctl: RTL and testbench

Load/store control stage of the c7bexu execute unit. It accepts one memory operation per issue from the E stage, checks alignment in LS1, runs a single outstanding request/response transaction on the bus interface, and returns LS3 completion and exception pulses. The ECL consumes these pulses to release `stall_ifu`/`stall_m`. Load data is aligned and extended before it is returned.

---
 rtl/c7bexu_lsu_ctl.sv | 201 ++++++++++++++++++++
 tb/tb_c7bexu_lsu_ctl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c7bexu_lsu_ctl.sv
// c7bexu_lsu_ctl -- load/store control stage of the c7bexu execute unit.
//
// Accepts one memory op from E, checks alignment in LS1, runs a single
// outstanding request/response transaction on the BIU, and returns one
// LS3 completion or exception pulse per op. Load data is shifted into
// place and sign/zero extended before being registered.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   lsu_vld_e/op_e/uns_e    E-stage op: op[2]=store, op[1:0]=size (3 = word)
//   lsu_addr_e/wdata_e      E-stage effective address, right-justified data
//   lsu_busy                op in flight or LS3 pulse active
//   lsu_except_ale_ls1      misaligned address pulse (LS1)
//   lsu_badvaddr            address of the last accepted op
//   lsu_except_buserr_ls3   bus error pulse
//   lsu_except_ecc_ls3      load ECC error pulse
//   lsu_data_valid_ls3      load complete pulse, with lsu_rdata_ls3
//   lsu_wr_fin_ls3          store complete pulse
//   biu_req/wr/addr/size/wdata  request, held and stable until biu_ack
//   biu_ack                 request accepted
//   biu_rvalid/rdata/err/ecc_err response, accepted only in WAIT
//   lsu_state_dbg           current FSM state (IDLE=0, LS1=1, REQ=2, WAIT=3)
//
// Handshake: biu_req is a level held from entry to REQ until the cycle
// biu_ack is sampled high; the response is a single-cycle biu_rvalid that
// is only honoured once the FSM is in WAIT (never in the ack cycle).
//
// Build option: C7BEXU_LSU_ECC_EN enables load ECC error reporting.
// Without it lsu_except_ecc_ls3 is 0 and ECC-flagged loads complete normally.

module c7bexu_lsu_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_vld_e,
  input  logic [2:0]  lsu_op_e,
  input  logic        lsu_uns_e,
  input  logic [31:0] lsu_addr_e,
  input  logic [31:0] lsu_wdata_e,
  output logic        lsu_busy,
  output logic        lsu_except_ale_ls1,
  output logic [31:0] lsu_badvaddr,
  output logic        lsu_except_buserr_ls3,
  output logic        lsu_except_ecc_ls3,
  output logic        lsu_data_valid_ls3,
  output logic        lsu_wr_fin_ls3,
  output logic [31:0] lsu_rdata_ls3,
  output logic        biu_req,
  output logic        biu_wr,
  output logic [31:0] biu_addr,
  output logic [1:0]  biu_size,
  output logic [31:0] biu_wdata,
  input  logic        biu_ack,
  input  logic        biu_rvalid,
  input  logic [31:0] biu_rdata,
  input  logic        biu_err,
  input  logic        biu_ecc_err,
  output logic [1:0]  lsu_state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LS1  = 2'd1,
    S_REQ  = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;
  logic        ecc_q, ecc_d;
  logic        dv_q, dv_d;
  logic        wf_q, wf_d;

  logic        is_word, is_half, is_store, misaligned, pulse_any, ecc_hit;
  logic [31:0] rdata_sh, rdata_ext, wdata_rep;

  // Size 3 is treated as word, so bit1 alone identifies word ops.
  assign is_word    = op_q[1];
  assign is_half    = (op_q[1:0] == 2'b01);
  assign is_store   = op_q[2];
  assign misaligned = (is_half & addr_q[0]) | (is_word & (addr_q[1:0] != 2'b00));
  assign pulse_any  = berr_q | ecc_q | dv_q | wf_q;

`ifdef C7BEXU_LSU_ECC_EN
  assign ecc_hit = biu_ecc_err & ~is_store;
`else
  assign ecc_hit = biu_ecc_err & 1'b0;
`endif

  // Word ops are aligned by the time they reach WAIT, so the shift is 0.
  assign rdata_sh = biu_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    rdata_ext = rdata_sh;
    if (op_q[1:0] == 2'b00)
      rdata_ext = uns_q ? {24'd0, rdata_sh[7:0]} : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
    else if (is_half)
      rdata_ext = uns_q ? {16'd0, rdata_sh[15:0]} : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
  end

  always_comb begin
    wdata_rep = wdata_q;
    if (op_q[1:0] == 2'b00)
      wdata_rep = {4{wdata_q[7:0]}};
    else if (is_half)
      wdata_rep = {2{wdata_q[15:0]}};
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    badvaddr_d = badvaddr_q;
    rdata_d    = rdata_q;
    berr_d     = 1'b0;
    ecc_d      = 1'b0;
    dv_d       = 1'b0;
    wf_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // An LS3 pulse still counts as busy, so issue is held off one cycle.
        if (lsu_vld_e && !pulse_any) begin
          op_d       = lsu_op_e;
          uns_d      = lsu_uns_e;
          addr_d     = lsu_addr_e;
          wdata_d    = lsu_wdata_e;
          badvaddr_d = lsu_addr_e;
          state_d    = S_LS1;
        end
      end
      S_LS1: state_d = misaligned ? S_IDLE : S_REQ;
      S_REQ: if (biu_ack) state_d = S_WAIT;
      S_WAIT: begin
        if (biu_rvalid) begin
          state_d = S_IDLE;
          if (biu_err)       berr_d = 1'b1;
          else if (ecc_hit)  ecc_d  = 1'b1;
          else if (is_store) wf_d   = 1'b1;
          else begin
            dv_d    = 1'b1;
            rdata_d = rdata_ext;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      badvaddr_q <= '0;
      rdata_q    <= '0;
      berr_q     <= 1'b0;
      ecc_q      <= 1'b0;
      dv_q       <= 1'b0;
      wf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      badvaddr_q <= badvaddr_d;
      rdata_q    <= rdata_d;
      berr_q     <= berr_d;
      ecc_q      <= ecc_d;
      dv_q       <= dv_d;
      wf_q       <= wf_d;
    end
  end

  assign lsu_state_dbg         = state_q;
  assign lsu_busy              = (state_q != S_IDLE) | pulse_any;
  assign lsu_except_ale_ls1    = (state_q == S_LS1) & misaligned;
  assign lsu_badvaddr          = badvaddr_q;
  assign lsu_except_buserr_ls3 = berr_q;
  assign lsu_except_ecc_ls3    = ecc_q;
  assign lsu_data_valid_ls3    = dv_q;
  assign lsu_wr_fin_ls3        = wf_q;
  assign lsu_rdata_ls3         = rdata_q;

  // Request fields are zero outside REQ so reset and idle look identical.
  assign biu_req   = (state_q == S_REQ);
  assign biu_wr    = biu_req & is_store;
  assign biu_addr  = biu_req ? (is_word ? {addr_q[31:2], 2'b00} : addr_q) : 32'd0;
  assign biu_size  = biu_req ? (is_word ? 2'd2 : op_q[1:0]) : 2'd0;
  assign biu_wdata = biu_req ? wdata_rep : 32'd0;

endmodule

// File: tb/tb_c7bexu_lsu_ctl.sv
module tb_c7bexu_lsu_ctl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lsu_vld_e = 1'b0;
  logic [2:0]  lsu_op_e = '0;
  logic        lsu_uns_e = 1'b0;
  logic [31:0] lsu_addr_e = '0;
  logic [31:0] lsu_wdata_e = '0;
  logic        lsu_busy, lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_except_ecc_ls3;
  logic        lsu_data_valid_ls3, lsu_wr_fin_ls3;
  logic [31:0] lsu_badvaddr, lsu_rdata_ls3;
  logic        biu_req, biu_wr;
  logic [31:0] biu_addr, biu_wdata;
  logic [1:0]  biu_size;
  logic        biu_ack = 1'b0, biu_rvalid = 1'b0, biu_err = 1'b0, biu_ecc_err = 1'b0;
  logic [31:0] biu_rdata = '0;
  logic [1:0]  lsu_state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  c7bexu_lsu_ctl dut (
    .clk(clk), .reset(reset),
    .lsu_vld_e(lsu_vld_e), .lsu_op_e(lsu_op_e), .lsu_uns_e(lsu_uns_e),
    .lsu_addr_e(lsu_addr_e), .lsu_wdata_e(lsu_wdata_e),
    .lsu_busy(lsu_busy), .lsu_except_ale_ls1(lsu_except_ale_ls1),
    .lsu_badvaddr(lsu_badvaddr), .lsu_except_buserr_ls3(lsu_except_buserr_ls3),
    .lsu_except_ecc_ls3(lsu_except_ecc_ls3), .lsu_data_valid_ls3(lsu_data_valid_ls3),
    .lsu_wr_fin_ls3(lsu_wr_fin_ls3), .lsu_rdata_ls3(lsu_rdata_ls3),
    .biu_req(biu_req), .biu_wr(biu_wr), .biu_addr(biu_addr), .biu_size(biu_size),
    .biu_wdata(biu_wdata), .biu_ack(biu_ack), .biu_rvalid(biu_rvalid),
    .biu_rdata(biu_rdata), .biu_err(biu_err), .biu_ecc_err(biu_ecc_err),
    .lsu_state_dbg(lsu_state_dbg)
  );

  // ---------------- scoreboard state ----------------
  localparam logic [2:0] K_ALE = 3'd1, K_BERR = 3'd2, K_ECC = 3'd3, K_DV = 3'd4, K_WF = 3'd5;

  // {kind[2:0], value[31:0], expected pulse cycle[31:0]}
  logic [66:0] exp_q[$];
  // {wr, addr[31:0], size[1:0], wdata[31:0]}
  logic [66:0] req_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [2:0] op);
    return (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
  endfunction

  // Returns {kind, value}: value is the loaded data for K_DV, else the address.
  function automatic logic [34:0] model_resp(input logic [2:0] op, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] rdata,
                                             input logic err, input logic ecc);
    int     nb;
    longint v;
    nb = nbytes_of(op);
    if ((addr % nb) != 0) return {K_ALE, addr};
    if (err)              return {K_BERR, addr};
    if (op[2])            return {K_WF, addr};
`ifdef C7BEXU_LSU_ECC_EN
    if (ecc)              return {K_ECC, addr};
`else
    if (ecc && 1'b0)      return {K_ECC, addr};
`endif
    v = longint'(rdata) / (longint'(1) << (8 * (addr % 4)));
    v = v % (longint'(1) << (8 * nb));
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v + (longint'(1) << 32) - (longint'(1) << (8 * nb));
    return {K_DV, v[31:0]};
  endfunction

  function automatic logic [66:0] model_req(input logic [2:0] op, input logic [31:0] addr,
                                            input logic [31:0] wdata);
    int          nb;
    logic [31:0] a, w;
    logic [1:0]  sz;
    nb = nbytes_of(op);
    a  = (nb == 4) ? addr - (addr % 4) : addr;
    sz = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
    w  = (nb == 1) ? (wdata % 256) * 32'h01010101 :
         (nb == 2) ? (wdata % 65536) * 32'h00010001 : wdata;
    return {op[2], a, sz, w};
  endfunction

  // ---------------- monitor ----------------
  logic        req_prev = 1'b0;
  logic        have_cur = 1'b0;
  logic [66:0] cur_req;

  always @(negedge clk) begin
    logic [4:0]  pulses;
    logic [2:0]  kind;
    logic [66:0] e;
    if (reset) begin
      req_prev = 1'b0;
      have_cur = 1'b0;
    end else begin
      pulses = {lsu_except_ale_ls1, lsu_except_buserr_ls3, lsu_except_ecc_ls3,
                lsu_data_valid_ls3, lsu_wr_fin_ls3};
      if (pulses != 5'd0) begin
        kind = lsu_except_ale_ls1 ? K_ALE : lsu_except_buserr_ls3 ? K_BERR :
               lsu_except_ecc_ls3 ? K_ECC : lsu_data_valid_ls3 ? K_DV : K_WF;
        check("pulse_onehot", $countones(pulses), 1);
        check("busy_during_pulse", {31'd0, lsu_busy}, 1);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_pulse");
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {29'd0, kind}, {29'd0, e[66:64]});
          check("pulse_cycle", cyc, e[31:0]);
          if (kind == K_DV) check("load_rdata", lsu_rdata_ls3, e[63:32]);
          else              check("badvaddr", lsu_badvaddr, e[63:32]);
        end
      end
      if (biu_req) begin
        if (!req_prev) begin
          if (req_q.size() == 0) begin
            fail_now("unexpected_biu_req");
            have_cur = 1'b0;
          end else begin
            cur_req  = req_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          check("biu_wr",    {31'd0, biu_wr},   {31'd0, cur_req[66]});
          check("biu_addr",  biu_addr,          cur_req[65:34]);
          check("biu_size",  {30'd0, biu_size}, {30'd0, cur_req[33:32]});
          check("biu_wdata", biu_wdata,         cur_req[31:0]);
        end
      end
      req_prev = biu_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_not_busy();
    int t = 0;
    while (lsu_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (lsu_busy) fail_now("busy_timeout");
  endtask

  task automatic issue(input logic [2:0] op, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, output int n);
    lsu_vld_e   = 1'b1;
    lsu_op_e    = op;
    lsu_uns_e   = uns;
    lsu_addr_e  = addr;
    lsu_wdata_e = wdata;
    n = cyc;
    @(negedge clk);
    lsu_vld_e = 1'b0;
  endtask

  // Waits for biu_req after an issue at cycle n; returns 1 if it appeared.
  task automatic wait_req(input int n, output bit ok);
    int t = 0;
    while (!biu_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = biu_req;
    if (!ok) fail_now("biu_req_timeout");
    else     check("req_latency", cyc, n + 2);
  endtask

  task automatic run_op(input logic [2:0] op, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_dly, input int rsp_dly,
                        input logic [31:0] rdata, input logic err, input logic ecc,
                        input bit junk);
    logic [34:0] m;
    int          n;
    bit          ok;
    @(negedge clk);
    wait_not_busy();
    m = model_resp(op, uns, addr, rdata, err, ecc);
    if (m[34:32] == K_ALE) begin
      exp_q.push_back({K_ALE, addr, cyc + 1});
      issue(op, uns, addr, wdata, n);
      repeat (4) @(negedge clk);
    end else begin
      req_q.push_back(model_req(op, addr, wdata));
      issue(op, uns, addr, wdata, n);
      wait_req(n, ok);
      if (ok) begin
        // Junk responses before/with the ack must be ignored by the DUT.
        for (int i = 0; i < ack_dly; i++) begin
          biu_rvalid = junk;
          biu_err    = junk;
          biu_rdata  = $urandom;
          @(negedge clk);
        end
        biu_ack    = 1'b1;
        biu_rvalid = junk;
        biu_err    = junk;
        @(negedge clk);
        biu_ack    = 1'b0;
        biu_rvalid = 1'b0;
        biu_err    = 1'b0;
        repeat (rsp_dly) @(negedge clk);
        biu_rvalid  = 1'b1;
        biu_rdata   = rdata;
        biu_err     = err;
        biu_ecc_err = ecc;
        exp_q.push_back({m, cyc + 1});
        @(negedge clk);
        biu_rvalid  = 1'b0;
        biu_err     = 1'b0;
        biu_ecc_err = 1'b0;
      end
    end
    wait_not_busy();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    bit  ok;
    // Reset values
    #1;
    check("rst_busy",     {31'd0, lsu_busy},              0);
    check("rst_ale",      {31'd0, lsu_except_ale_ls1},    0);
    check("rst_badvaddr", lsu_badvaddr,                   0);
    check("rst_berr",     {31'd0, lsu_except_buserr_ls3}, 0);
    check("rst_ecc",      {31'd0, lsu_except_ecc_ls3},    0);
    check("rst_dv",       {31'd0, lsu_data_valid_ls3},    0);
    check("rst_wf",       {31'd0, lsu_wr_fin_ls3},        0);
    check("rst_rdata",    lsu_rdata_ls3,                  0);
    check("rst_req",      {31'd0, biu_req},               0);
    check("rst_wr",       {31'd0, biu_wr},                0);
    check("rst_addr",     biu_addr,                       0);
    check("rst_size",     {30'd0, biu_size},              0);
    check("rst_wdata",    biu_wdata,                      0);
    check("rst_state",    {30'd0, lsu_state_dbg},         0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    // Directed cases
    run_op(3'b010, 1'b0, 32'h1000, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    run_op(3'b000, 1'b0, 32'h1003, 32'h0, 0, 0, 32'h80AABBCC, 1'b0, 1'b0, 1'b0);
    run_op(3'b000, 1'b1, 32'h1003, 32'h0, 0, 0, 32'h80AABBCC, 1'b0, 1'b0, 1'b0);
    run_op(3'b101, 1'b0, 32'h2001, 32'h1234, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op(3'b100, 1'b0, 32'h3002, 32'h5A, 3, 1, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op(3'b010, 1'b0, 32'h4000, 32'h0, 0, 0, 32'h12345678, 1'b1, 1'b1, 1'b0);
    run_op(3'b010, 1'b0, 32'h4004, 32'h0, 0, 0, 32'h87654321, 1'b0, 1'b1, 1'b0);
    run_op(3'b110, 1'b0, 32'h4008, 32'hCAFEF00D, 1, 0, 32'h0, 1'b0, 1'b1, 1'b1);
    run_op(3'b011, 1'b0, 32'h400C, 32'h0, 0, 2, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);

    // Reset asserted while waiting for the response
    @(negedge clk);
    wait_not_busy();
    req_q.push_back(model_req(3'b010, 32'h5000, 32'h0));
    issue(3'b010, 1'b0, 32'h5000, 32'h0, n);
    wait_req(n, ok);
    biu_ack = 1'b1;
    @(negedge clk);
    biu_ack = 1'b0;
    check("pre_reset_state", {30'd0, lsu_state_dbg}, 3);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_req",   {31'd0, biu_req},       0);
    check("mid_reset_state", {30'd0, lsu_state_dbg}, 0);
    check("mid_reset_busy",  {31'd0, lsu_busy},      0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    biu_rvalid = 1'b1;
    biu_rdata  = 32'hFFFF0000;
    @(negedge clk);
    biu_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {30'd0, lsu_state_dbg}, 0);
    run_op(3'b001, 1'b0, 32'h5002, 32'h0, 0, 0, 32'h8001_7FFF, 1'b0, 1'b0, 1'b0);

    // Randomized ops
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] addr;
      op   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = (op[1:0] == 2'd1) ? {addr[1], 1'b0} :
                                                 (op[1] ? 2'b00 : addr[1:0]);
      run_op(op, 1'($urandom_range(0, 1)), addr, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
